multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control unit for the multicycle RV32I core. It replaces the single-cycle combinational decode with a registered FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Branch resolution uses the Zero/lt/ltu flags, as before. New behaviour: memory wait-state handshake, U-type immediate support (lui/auipc), two-step jalr, and illegal-instruction detection with selectable trap/skip mode.
- Sits between the instruction register/ALU flags and the multicycle datapath muxes and enables.

Parameters:
- MEM_HANDSHAKE, 1, 1: memory states hold until mem_ready=1. 0: mem_ready is ignored and treated as 1.
- TRAP_ON_ILLEGAL, 1, 1: an illegal instruction enters TRAP until reset. 0: it is skipped and the FSM returns to FETCH.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH
- op  in  7  opcode field of instruction register
- funct3  in  3  funct3 field of instruction register
- Zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult, 11 = ImmExt
- ALUSrcA  out  2  ALU A input: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B input: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded
- ImmSrc  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- illegal_instr  out  1  illegal instruction indication
- state_dbg  out  4  current state encoding

Behaviour:
- Moore FSM with a 4-bit state register. Outputs are combinational from state, plus funct3/flags in BRANCH and mem_ready in memory states.
- Default for every output not listed in a state: 0. ready = mem_ready OR (MEM_HANDSHAKE == 0).
- ImmSrc is combinational from op in all states: load/jalr/OP-IMM = 000, store = 001, branch = 010, jal = 011, lui/auipc = 100, otherwise 000.
- Reset: state = FETCH. While reset is high, PCWrite, IRWrite, MemRead, MemWrite and RegWrite are forced to 0; illegal_instr = 0.
- Reset asserted mid-sequence (including a memory wait) aborts it. No partial write occurs after the reset edge.
- State 0, FETCH:
  - Outputs: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=ready.
  - Transition: -> DECODE when ready, else stay.
- State 1, DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jal target into ALUOut).
  - Transitions by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR1
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - any other op, or branch with funct3 010/011 -> TRAP if TRAP_ON_ILLEGAL, else FETCH. illegal_instr=1 during this DECODE cycle.
- State 2, MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. -> MEMREAD if op[5]=0, else MEMWRITE.
- State 3, MEMREAD: AdrSrc=1, MemRead=1. -> MEMWB when ready, else stay.
- State 4, MEMWB: ResultSrc=01, RegWrite=1. -> FETCH.
- State 5, MEMWRITE:
  - Outputs: AdrSrc=1, MemWrite=1, held until ready.
  - Transition: -> FETCH in the ready cycle. MemWrite is deasserted from the next cycle.
- State 6, EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. -> ALUWB.
- State 7, EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. -> ALUWB.
- State 8, ALUWB: ResultSrc=00, RegWrite=1. -> FETCH.
- State 9, BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=take.
  - take by funct3: 000 = Zero, 001 = !Zero, 100 = lt, 101 = !lt, 110 = ltu, 111 = !ltu.
  - Transition: -> FETCH.
- State 10, JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. -> ALUWB (writes OldPC+4).
- State 11, JALR1: ALUSrcA=10, ALUSrcB=01, ALUOp=00. -> JALR2.
- State 12, JALR2: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ALUOp=00. -> ALUWB. The datapath clears target bit 0.
- State 13, LUI: ResultSrc=11, RegWrite=1. -> FETCH.
- State 14, AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00. -> ALUWB.
- State 15, TRAP: illegal_instr=1, all enables 0. Stays in TRAP until reset.
- Latencies with ready=1 every cycle (cycles per instruction):
  - load 5, store 4
  - R/I-type 4
  - branch 3, jal 4, jalr 5
  - lui 3, auipc 4

Test Plan:
- reset high mid-MEMWRITE -> state_dbg=0 immediately and MemWrite=0. After release, FETCH with MemRead=1.
- add (op=0110011), mem_ready=1 -> states 0,1,6,8,0. RegWrite=1 only in the ALUWB cycle, with ALUOp=10 in EXECR.
- lw with MEM_HANDSHAKE=1, mem_ready low for 3 cycles in MEMREAD -> stays in state 3 for 4 cycles, then MEMWB with ResultSrc=01 and RegWrite=1. Same lw with MEM_HANDSHAKE=0 -> exactly 5 cycles.
- Each branch funct3 in {000, 001, 100, 101, 110, 111} × each flag combination -> PCWrite in BRANCH equals the table above. Branch funct3=010 -> illegal_instr pulse in DECODE.
- jalr -> states 0,1,11,12,8. PCWrite=1 only in FETCH and JALR2. lui -> ImmSrc=100, ResultSrc=11, RegWrite=1, 3 cycles total.
- op=1111111: TRAP_ON_ILLEGAL=1 -> state 15 with illegal_instr held high for 20 cycles and no enables. TRAP_ON_ILLEGAL=0 -> back to FETCH after one illegal_instr pulse.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: registered FSM sequencing fetch, decode,
// execute, memory and writeback, with memory wait states, U-type support,
// two-step jalr and illegal-instruction detection (trap or skip).
//
// Memory handshake: a memory state (FETCH, MEMREAD, MEMWRITE) completes in
// the cycle where ready is high; its request/strobe stays asserted in every
// cycle until then, and the FSM advances on the clock edge that ends the
// ready cycle.
module multicycle_controller #(
    parameter logic MEM_HANDSHAKE   = 1'b1,
    parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t state_q;
    state_t state_d;
    logic   ready;
    logic   take;

    assign state_dbg = state_q;

    // Memory completion: with the handshake disabled every access is single-cycle.
    assign ready = mem_ready | ~MEM_HANDSHAKE;

    // Branch condition from ALU compare flags; funct3 010/011 never reach BRANCH.
    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = Zero;
            3'b001:  take = ~Zero;
            3'b100:  take = lt;
            3'b101:  take = ~lt;
            3'b110:  take = ltu;
            3'b111:  take = ~ltu;
            default: take = 1'b0;
        endcase
    end

    // Immediate format depends only on the opcode, in every state.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:          ImmSrc = 3'b001;
            OP_BRANCH:         ImmSrc = 3'b010;
            OP_JAL:            ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
            default:           ImmSrc = 3'b000;
        endcase
    end

    // State register; reset aborts any sequence, including a memory wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore outputs; enables are masked while reset is high.
    always_comb begin
        state_d       = state_q;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        illegal_instr = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                PCWrite   = ready;
                if (ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    OP_BRANCH: begin
                        if (funct3[2:1] == 2'b01) begin
                            illegal_instr = 1'b1;
                            state_d       = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                        end else begin
                            state_d = S_BRANCH;
                        end
                    end
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                if (ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                PCWrite = take;
                state_d = S_FETCH;
            end
            S_JAL: begin
                // PC <- branch target from DECODE; ALU forms OldPC+4 for rd.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = S_JALR2;
            end
            S_JALR2: begin
                // Target rs1+imm sits in ALUOut; datapath clears bit 0.
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                state_d       = S_TRAP;
            end
            default: state_d = S_FETCH;
        endcase

        if (reset) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            MemRead       = 1'b0;
            MemWrite      = 1'b0;
            RegWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule
